// File: rtl/hog_frame_sched.sv
// Per-frame sequencer for the HOG pipeline: streams one image from BRAM into the HOG pixel port,
// then waits for histogram and feature-write completion. Optional perf counter: HOG_SCHED_PERF_EN.
module hog_frame_sched #(
    parameter int RAM_AW      = 17,
    parameter int IMAGE_SIZE  = 18495,
    parameter int P_WIDTH     = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               aclk,
    input  logic               arest,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [RAM_AW-1:0]  img_addr,
    output logic               img_en,
    input  logic [P_WIDTH-1:0] img_dout,
    input  logic               hog_ready,
    output logic [P_WIDTH-1:0] p,
    output logic               p_valid,
    output logic               finish,
    input  logic               histogram_done,
    input  logic               write_feature_done,
    output logic [15:0]        frame_cnt
`ifdef HOG_SCHED_PERF_EN
    ,
    output logic [31:0]        cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_STREAM, S_FLUSH, S_FIN, S_WAIT_HIST, S_WAIT_WR, S_DONE
    } state_t;

    localparam logic [RAM_AW-1:0] ADDR_LAST = RAM_AW'(IMAGE_SIZE);
    localparam logic [31:0]       WAIT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam bit                TO_EN     = (TIMEOUT_CYC != 0);

    state_t              state_q, state_d;
    logic [RAM_AW-1:0]   addr_q;
    logic [31:0]         wait_q;
    logic                en_d1_q, pv_q, fin_q, err_q;
    logic [P_WIDTH-1:0]  p_q;
    logic [15:0]         frame_q;
    logic                abort_hit, accept, waiting, to_hit, frame_ok;

    assign abort_hit = abort && (state_q != S_IDLE);
    assign accept    = (state_q == S_IDLE) && start;
    assign waiting   = (state_q == S_WAIT_HIST) || (state_q == S_WAIT_WR);
    assign to_hit    = TO_EN && waiting && (wait_q == WAIT_LAST);
    assign frame_ok  = (state_q == S_DONE) && !abort;

    always_ff @(posedge aclk) begin
        if (arest) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      if (start) state_d = S_WAIT_RDY;
                S_WAIT_RDY:  if (hog_ready) state_d = S_STREAM;
                S_STREAM:    if (addr_q == ADDR_LAST) state_d = S_FLUSH;
                S_FLUSH:     state_d = S_FIN;
                S_FIN:       state_d = S_WAIT_HIST;
                // a completion seen on the deadline cycle still counts
                S_WAIT_HIST: if (histogram_done) state_d = S_WAIT_WR;
                             else if (to_hit)    state_d = S_IDLE;
                S_WAIT_WR:   if (write_feature_done) state_d = S_DONE;
                             else if (to_hit)        state_d = S_IDLE;
                S_DONE:      state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        img_en    = (state_q == S_STREAM) && !abort;
        done      = frame_ok;
        finish    = fin_q && !abort;
        p_valid   = pv_q;
        p         = p_q;
        img_addr  = addr_q;
        err       = err_q;
        frame_cnt = frame_q;
    end

    // Two-stage pixel path: BRAM read latency plus the output register.
    always_ff @(posedge aclk) begin
        if (arest) begin
            addr_q  <= '0;
            wait_q  <= '0;
            en_d1_q <= 1'b0;
            pv_q    <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            p_q     <= '0;
            frame_q <= '0;
        end else begin
            en_d1_q <= img_en;
            pv_q    <= en_d1_q && !abort_hit;
            p_q     <= img_dout;
            fin_q   <= (state_q == S_FIN) && !abort;
            if ((state_q == S_WAIT_RDY) && hog_ready)
                addr_q <= '0;
            else if (img_en && (addr_q != ADDR_LAST))
                addr_q <= addr_q + RAM_AW'(1);
            wait_q <= (waiting && (state_d == state_q)) ? wait_q + 32'd1 : 32'd0;
            if (accept)
                err_q <= 1'b0;
            else if (abort_hit || (to_hit && (state_d == S_IDLE)))
                err_q <= 1'b1;
            if (frame_ok)
                frame_q <= frame_q + 16'd1;
        end
    end

`ifdef HOG_SCHED_PERF_EN
    logic [31:0] run_q, cyc_q;

    always_ff @(posedge aclk) begin
        if (arest) begin
            run_q <= '0;
            cyc_q <= '0;
        end else begin
            if (accept)
                run_q <= 32'd1;
            else if ((state_q != S_IDLE) && (run_q != 32'hFFFF_FFFF))
                run_q <= run_q + 32'd1;
            if (frame_ok)
                cyc_q <= run_q;
        end
    end

    assign cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_hog_frame_sched.sv
// Bench for hog_frame_sched: scripted frame scenarios plus random traffic, checked every cycle
// against a frame-timeline model.
module tb_hog_frame_sched;
    localparam int N  = 16;
    localparam int TO = 100;
    localparam int M_IDLE = 0, M_RDY = 1, M_RUN = 2, M_HIST = 3, M_WR = 4, M_DN = 5;

    logic aclk = 0, arest = 1, start = 0, abort = 0, hog_ready = 0, hd = 0, wd = 0;
    logic [7:0]  img_dout = '0;
    logic        busy, done, err, img_en, p_valid, finish;
    logic [16:0] img_addr;
    logic [7:0]  p;
    logic [15:0] frame_cnt;
`ifdef HOG_SCHED_PERF_EN
    logic [31:0] cycle_cnt;
`endif

    hog_frame_sched #(.RAM_AW(17), .IMAGE_SIZE(N - 1), .P_WIDTH(8), .TIMEOUT_CYC(TO)) dut (
        .aclk(aclk), .arest(arest), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .img_addr(img_addr), .img_en(img_en), .img_dout(img_dout),
        .hog_ready(hog_ready), .p(p), .p_valid(p_valid), .finish(finish),
        .histogram_done(hd), .write_feature_done(wd), .frame_cnt(frame_cnt)
`ifdef HOG_SCHED_PERF_EN
        , .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    logic [7:0] mem [0:N-1];
    always @(posedge aclk) if (img_en) img_dout <= mem[img_addr[3:0]];

    int nchk = 0, nerr = 0, cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Model: a frame is a timeline; t counts cycles since streaming began (reads at t<N,
    // pixels at t=2..N+1), followed by two bounded waits and a one-cycle done.
    int ph = M_IDLE, t = 0, ent = 0, acc = 0;
    bit mdl_ok = 0;
    logic m_err = 0;
    logic [15:0] m_fc = 0;
    logic [31:0] m_cyc = 0;

    always @(posedge aclk) begin
        if (arest) begin
            ph = M_IDLE; t = 0; m_err = 0; m_fc = 0; m_cyc = 0; mdl_ok = 1;
        end else if (mdl_ok) begin
            if (ph == M_IDLE) begin
                if (start) begin ph = M_RDY; m_err = 0; acc = cyc; end
            end else if (abort) begin
                ph = M_IDLE; m_err = 1;
            end else begin
                case (ph)
                    M_RDY:  if (hog_ready) begin ph = M_RUN; t = 0; end
                    M_RUN:  if (t == N + 1) begin ph = M_HIST; ent = cyc + 1; end else t++;
                    M_HIST: if (hd) begin ph = M_WR; ent = cyc + 1; end
                            else if (cyc - ent + 1 >= TO) begin ph = M_IDLE; m_err = 1; end
                    M_WR:   if (wd) ph = M_DN;
                            else if (cyc - ent + 1 >= TO) begin ph = M_IDLE; m_err = 1; end
                    default: begin ph = M_IDLE; m_fc++; m_cyc = cyc - acc; end
                endcase
            end
        end
        cyc++;
    end

    int pv_cnt, fin_cnt, done_cnt, first_pv, last_pv, first_en, fin_cyc, done_cyc;

    always @(negedge aclk) begin
        if (mdl_ok) begin
            logic e_en, e_pv, e_fin, e_done;
            e_en   = (ph == M_RUN) && (t < N) && !abort;
            e_pv   = (ph == M_RUN) && (t >= 2) && (t <= N + 1);
            e_fin  = (ph == M_HIST) && (cyc == ent) && !abort;
            e_done = (ph == M_DN) && !abort;
            chk("busy", busy, ph != M_IDLE);
            chk("err", err, m_err);
            chk("frame_cnt", frame_cnt, m_fc);
            chk("img_en", img_en, e_en);
            chk("p_valid", p_valid, e_pv);
            chk("finish", finish, e_fin);
            chk("done", done, e_done);
            if (e_en) chk("img_addr", img_addr, t);
            if (e_pv) chk("p", p, mem[t-2]);
`ifdef HOG_SCHED_PERF_EN
            chk("cycle_cnt", cycle_cnt, m_cyc);
`endif
        end
        if (p_valid) begin pv_cnt++; last_pv = cyc; if (first_pv < 0) first_pv = cyc; end
        if (img_en && first_en < 0) first_en = cyc;
        if (finish) begin fin_cnt++; fin_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    task automatic step();   @(posedge aclk); #1; endtask
    task automatic sample(); @(negedge aclk); #1; endtask

    task automatic clr_mon();
        pv_cnt = 0; fin_cnt = 0; done_cnt = 0; first_pv = -1; last_pv = -1;
        first_en = -1; fin_cyc = -1; done_cyc = -1;
    endtask

    int s;
    task automatic go();
        clr_mon(); start = 1; s = cyc; step(); start = 0;
    endtask

    task automatic run_back(input int dh, input int dw);
        for (int i = 0; i < 300 && fin_cnt == 0; i++) sample();
        chk("finish_seen", fin_cnt != 0, 1);
        repeat (dh) step();
        hd = 1; step(); hd = 0;
        repeat (dw) step();
        wd = 1; step(); wd = 0;
        for (int i = 0; i < 20 && busy; i++) sample();
        chk("idle_after_frame", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr_mon();
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        arest = 1; repeat (3) step();
        sample();
        chk("rst_busy", busy, 0);       chk("rst_err", err, 0);
        chk("rst_frame_cnt", frame_cnt, 0); chk("rst_img_en", img_en, 0);
        chk("rst_p_valid", p_valid, 0); chk("rst_finish", finish, 0);
        chk("rst_img_addr", img_addr, 0); chk("rst_p", p, 0);
        step(); arest = 0; step();

        // Basic frame with completion at +50/+80 after finish
        hog_ready = 1; go();
        run_back(50, 29);
        chk("t1_pv_count", pv_cnt, 16);
        chk("t1_pv_contig", last_pv - first_pv, 15);
        chk("t1_first_en", first_en - s, 2);
        chk("t1_first_pv", first_pv - s, 4);
        chk("t1_fin_after_pv", fin_cyc - last_pv, 1);
        chk("t2_done_lat", done_cyc - fin_cyc, 81);
        chk("t2_done_count", done_cnt, 1);
        chk("t2_frame_cnt", frame_cnt, 1);
`ifdef HOG_SCHED_PERF_EN
        chk("t6_cycle_cnt", cycle_cnt, 101);
`endif

        // hog_ready held low for 20 cycles
        hog_ready = 0; go();
        repeat (19) step();
        hog_ready = 1;
        begin
            int r;
            r = cyc;
            run_back(3, 4);
            chk("t3_first_en", first_en, r + 1);
        end
        chk("t3_frame_cnt", frame_cnt, 2);

        // abort on the 8th pixel, then a clean frame
        go();
        for (int i = 0; i < 100 && pv_cnt < 7; i++) sample();
        step(); abort = 1; step(); abort = 0;
        repeat (30) step();
        sample();
        chk("t4_pv_count", pv_cnt, 8);
        chk("t4_no_finish", fin_cnt, 0);
        chk("t4_err", err, 1);
        chk("t4_busy", busy, 0);
        chk("t4_frame_cnt", frame_cnt, 2);
        go(); sample();
        chk("t4_err_clr", err, 0);
        run_back(5, 5);
        chk("t4_full_pv", pv_cnt, 16);
        chk("t4_frame_cnt2", frame_cnt, 3);

        // histogram_done never arrives
        go();
        for (int i = 0; i < 100 && fin_cnt == 0; i++) sample();
        for (int i = 0; i < 300 && busy; i++) sample();
        chk("t5_to_lat", cyc - fin_cyc, 100);
        chk("t5_err", err, 1);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_frame_cnt", frame_cnt, 3);

        // start repeated while the frame is running
        clr_mon(); start = 1; s = cyc; repeat (6) step(); start = 0;
        run_back(2, 2);
        repeat (5) step();
        chk("t6_one_done", done_cnt, 1);
        chk("t6_frame_cnt", frame_cnt, 4);

        // random traffic including aborts, timeouts and mid-frame resets
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 19) == 0);
            abort     = ($urandom_range(0, 299) == 0);
            hog_ready = ($urandom_range(0, 2) == 0);
            hd        = ($urandom_range(0, 49) == 0);
            wd        = ($urandom_range(0, 49) == 0);
            arest     = ($urandom_range(0, 1999) == 0);
            step();
        end
        start = 0; abort = 0; hog_ready = 0; hd = 0; wd = 0; arest = 0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
